// File: rtl/bus_unpacker.sv
// -----------------------------------------------------------------------------
// bus_unpacker
//
// Downstream consumer of the 24-bit valid/ready bus stage. Each input word is
// held in a one-entry buffer and emitted as RATIO = IN_W/OUT_W narrower beats,
// most-significant slice first. The final beat of every word is flagged with
// out_last. A word waiting upstream is loaded on the same edge the last beat
// of the current word leaves, so consecutive words stream out with no bubble.
//
// Parameters
//   IN_W   input word width (integer multiple of OUT_W)
//   OUT_W  output beat width (IN_W/OUT_W >= 2)
//   CNT_W  beat counter width (2**CNT_W >= IN_W/OUT_W)
//
// Ports
//   clk        in   system clock, rising edge
//   RST        in   asynchronous, active-high reset
//   in_valid   in   upstream word valid
//   in_data    in   upstream word [IN_W]
//   in_ready   out  a word can be taken this cycle (forced low during RST)
//   out_valid  out  out_data holds a valid beat
//   out_data   out  current beat [OUT_W], zero while empty
//   out_ready  in   downstream accepts the beat
//   out_last   out  current beat is the final slice of its word
//   busy       out  a word is held
// -----------------------------------------------------------------------------
module bus_unpacker #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 8,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int               RATIO    = IN_W / OUT_W;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    logic             full;
    logic [IN_W-1:0]  data_q;
    logic [CNT_W-1:0] cnt;

    logic in_fire;
    logic out_fire;

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    assign out_valid = full;
    assign busy      = full;
    assign out_last  = full && (cnt == LAST_CNT);

    // The out_ready -> in_ready path is combinational on purpose: it lets the
    // next word load on the very edge the last beat is consumed.
    assign in_ready = !RST && (!full || (out_ready && out_last));

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Beat select: cnt = 0 picks the most-significant slice.
    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        out_data = '0;
        if (full) begin
            for (int i = 0; i < RATIO; i++) begin
                if (cnt == CNT_W'(RATIO - 1 - i)) begin
                    out_data = data_q[i*OUT_W +: OUT_W];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word buffer and beat counter
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, whatever the order.
    // NOTE: data_q is cleared on reset as well as the control bits, so nothing
    // of a word in flight can reappear after reset is released.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            full   <= 1'b0;
            cnt    <= '0;
            data_q <= '0;
        end else if (!full) begin
            if (in_fire) begin
                data_q <= in_data;
                cnt    <= '0;
                full   <= 1'b1;
            end
        end else if (out_fire) begin
            if (cnt != LAST_CNT) begin
                cnt <= cnt + 1'b1;
            end else if (in_valid) begin
                // Chained word: last beat leaves and the next word arrives
                // on the same edge, so full stays set.
                data_q <= in_data;
                cnt    <= '0;
            end else begin
                full <= 1'b0;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_unpacker.sv
// -----------------------------------------------------------------------------
// tb_bus_unpacker
//
// Directed scenarios followed by randomized traffic. Accepted words are turned
// into their expected beat sequence by plain shifting and queued; a monitor
// compares the DUT's presented beat, flags and in_ready against that queue
// every cycle and pops on each beat handshake.
// -----------------------------------------------------------------------------
module tb_bus_unpacker;

    localparam int IN_W  = 24;
    localparam int OUT_W = 8;
    localparam int CNT_W = 2;
    localparam int RATIO = IN_W / OUT_W;

    logic             clk;
    logic             RST;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;
    logic             out_last;
    logic             busy;

    bus_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    bit    rand_ready = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a word becomes RATIO beats, most-significant slice first.
    task automatic push_word(input logic [IN_W-1:0] w);
        int    word;
        beat_t b;
        word = int'(w);
        for (int k = 0; k < RATIO; k++) begin
            b.data = OUT_W'((word >> ((RATIO - 1 - k) * OUT_W)) & ((1 << OUT_W) - 1));
            b.last = (k == RATIO - 1);
            exp_q.push_back(b);
        end
    endtask

    // Monitor: samples 4 time units after the falling edge, i.e. just before
    // the rising edge, once all inputs for the cycle are settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (RST) begin
                exp_q.delete();
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_out_data",  32'(out_data),  32'd0);
                check("rst_out_last",  32'(out_last),  32'd0);
                check("rst_busy",      32'(busy),      32'd0);
                check("rst_in_ready",  32'(in_ready),  32'd0);
            end else begin
                check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
                check("busy",      32'(busy),      32'(exp_q.size() != 0));
                // Empty buffer, or only the last beat left and it leaves now.
                check("in_ready",  32'(in_ready),
                      32'(exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)));
                if (exp_q.size() != 0) begin
                    check("out_data", 32'(out_data), 32'(exp_q[0].data));
                    check("out_last", 32'(out_last), 32'(exp_q[0].last));
                end else begin
                    check("idle_out_data", 32'(out_data), 32'd0);
                    check("idle_out_last", 32'(out_last), 32'd0);
                end
                if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (in_valid && in_ready) push_word(in_data);
            end
        end
    end

    // Random downstream backpressure when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer one word until it is taken; leaves the bench at the falling edge
    // after the accepting rising edge with in_valid dropped.
    task automatic offer(input logic [IN_W-1:0] w);
        bit taken = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 200 && !taken; c++) begin
            #4;
            taken = in_ready;
            @(negedge clk);
        end
        if (!taken) check("offer_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_data  = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        check("por_out_valid", 32'(out_valid), 32'd0);
        check("por_in_ready",  32'(in_ready),  32'd0);
        idle(2);
        RST = 1'b0;
        idle(1);

        // 1. single word
        offer(24'hFFF000);
        idle(4);

        // 2. back-to-back words
        offer(24'h000FFF);
        offer(24'h555555);
        idle(4);

        // 3. backpressure on a middle beat
        offer(24'h112233);
        @(negedge clk);              // 22 is now presented
        out_ready = 1'b0;
        idle(3);
        out_ready = 1'b1;
        idle(4);

        // 4. backpressure on the last beat with the next word pending
        offer(24'h445566);
        @(negedge clk);              // 55
        @(negedge clk);              // 66
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 24'h667788;
        idle(3);
        out_ready = 1'b1;
        offer(24'h667788);
        idle(4);

        // 5. reset during beat 22
        offer(24'h112233);
        @(negedge clk);              // 22
        #1 RST = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        idle(1);
        RST = 1'b0;
        idle(1);
        offer(24'h222222);
        idle(4);

        // 6. idle gaps
        offer(24'h111111);
        idle(5);
        offer(24'h333333);
        idle(5);

        // Random traffic with random downstream backpressure.
        rand_ready = 1;
        for (int n = 0; n < 300; n++) begin
            offer(IN_W'($urandom()));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
        end
        rand_ready = 0;
        out_ready  = 1'b1;
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
